// File: rtl/even_count_monitor_if.sv
// Signal bundle between an even up/down counter and its monitor.
// The master side drives the counter taps and controls; the slave side is the monitor.
interface even_count_monitor_if;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       Y;
    logic       en;
    logic       err_clr;
    logic [3:0] count;
    logic       err;
    logic       err_sticky;
    logic [7:0] err_cnt;
    logic       wrap;
    logic [7:0] wrap_cnt;
    logic [1:0] state;

    modport master (
        output A, B, C, D, Y, en, err_clr,
        input  count, err, err_sticky, err_cnt, wrap, wrap_cnt, state
    );

    modport slave (
        input  A, B, C, D, Y, en, err_clr,
        output count, err, err_sticky, err_cnt, wrap, wrap_cnt, state
    );
endinterface

// File: rtl/even_count_monitor.sv
// Checks that an even up/down counter steps by +/-2 each cycle and keeps error/wrap statistics.
// Optional macro MON_WRAP_CNT_EN enables the wrap pulse and wrap counter; otherwise both read 0.
module even_count_monitor (
    input logic                  clock,
    input logic                  reset,
    even_count_monitor_if.slave  bus
);
    localparam logic [1:0] SYNC  = 2'b00;
    localparam logic [1:0] TRACK = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;

    logic [1:0] state_q, state_d;
    logic [3:0] prev, sample, exp_val, count_q;
    logic       yprev;
    logic [1:0] miss, miss_base, miss_d;
    logic       illegal, match, load, err_ev;
    logic       err_q, sticky_q, sticky_d;
    logic [7:0] err_cnt_q, err_cnt_base, err_cnt_d;

    always_comb begin
        sample  = {bus.A, bus.B, bus.C, bus.D};
        illegal = bus.D;
        exp_val = yprev ? prev + 4'd2 : prev - 4'd2;
        // a resync onto an odd value makes exp odd too, so legality is checked separately
        match     = !illegal && (sample == exp_val);
        miss_base = bus.err_clr ? 2'd0 : miss;

        state_d = state_q;
        miss_d  = miss_base;
        load    = 1'b0;
        err_ev  = 1'b0;

        if (!bus.en) begin
            state_d = SYNC;
            miss_d  = 2'd0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (illegal) begin
                        err_ev = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    load = 1'b1;
                    if (match) begin
                        miss_d = 2'd0;
                    end else begin
                        err_ev = 1'b1;
                        miss_d = miss_base + 2'd1;
                        if (miss_d == 2'd3)
                            state_d = FAULT;
                    end
                end
                FAULT: begin
                    if (bus.err_clr)
                        state_d = SYNC;
                end
                default: state_d = SYNC;
            endcase
        end

        // clear first, then apply a same-edge event on top of the cleared value
        err_cnt_base = bus.err_clr ? 8'd0 : err_cnt_q;
        err_cnt_d    = (err_ev && err_cnt_base != 8'hFF) ? err_cnt_base + 8'd1 : err_cnt_base;
        sticky_d     = err_ev | (sticky_q & ~bus.err_clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SYNC;
            prev      <= 4'd0;
            yprev     <= 1'b0;
            miss      <= 2'd0;
            count_q   <= 4'd0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            miss      <= miss_d;
            count_q   <= sample;
            err_q     <= err_ev;
            sticky_q  <= sticky_d;
            err_cnt_q <= err_cnt_d;
            if (load) begin
                prev  <= sample;
                yprev <= bus.Y;
            end
        end
    end

`ifdef MON_WRAP_CNT_EN
    logic       wrap_step, wrap_ev, wrap_q;
    logic [7:0] wrap_cnt_q, wrap_cnt_base, wrap_cnt_d;

    always_comb begin
        wrap_step = (yprev  && prev == 4'd14 && sample == 4'd0) ||
                    (!yprev && prev == 4'd0  && sample == 4'd14);
        // only a step that matched the expected value counts as a wrap
        wrap_ev       = bus.en && (state_q == TRACK) && match && wrap_step;
        wrap_cnt_base = bus.err_clr ? 8'd0 : wrap_cnt_q;
        wrap_cnt_d    = (wrap_ev && wrap_cnt_base != 8'hFF) ? wrap_cnt_base + 8'd1 : wrap_cnt_base;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrap_q     <= 1'b0;
            wrap_cnt_q <= 8'd0;
        end else begin
            wrap_q     <= wrap_ev;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.wrap     = wrap_q;
    assign bus.wrap_cnt = wrap_cnt_q;
`else
    assign bus.wrap     = 1'b0;
    assign bus.wrap_cnt = 8'd0;
`endif

    assign bus.count      = count_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_even_count_monitor.sv
// Directed bench for even_count_monitor; wrap expectations follow MON_WRAP_CNT_EN.
module tb_even_count_monitor;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

`ifdef MON_WRAP_CNT_EN
    localparam logic       EXP_WRAP   = 1'b1;
    localparam logic [7:0] EXP_WRAP_N = 8'd1;
`else
    localparam logic       EXP_WRAP   = 1'b0;
    localparam logic [7:0] EXP_WRAP_N = 8'd0;
`endif

    even_count_monitor_if mon();

    even_count_monitor dut (
        .clock (clock),
        .reset (reset),
        .bus   (mon)
    );

    always #5 clock = ~clock;

    // drive one sample, take the edge, settle 1 time unit past it
    task automatic apply(input logic [3:0] v, input logic y);
        {mon.A, mon.B, mon.C, mon.D} = v;
        mon.Y = y;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mon.en = 1'b0;
        mon.err_clr = 1'b0;
        apply(4'd0, 1'b0);
        reset = 1'b0;
        mon.en = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mon.en = 1'b1;
        mon.err_clr = 1'b1;
        apply(4'd7, 1'b1);
        total_cnt++; if (mon.state !== 2'b00) $display("FAIL reset_state got %0d want 0", mon.state); else pass_cnt++;
        total_cnt++; if (mon.count !== 4'd0) $display("FAIL reset_count got %0d want 0", mon.count); else pass_cnt++;
        total_cnt++; if ({mon.err, mon.err_sticky, mon.err_cnt} !== 10'd0)
            $display("FAIL reset_err got %b/%b/%0d want 0/0/0", mon.err, mon.err_sticky, mon.err_cnt); else pass_cnt++;
        total_cnt++; if ({mon.wrap, mon.wrap_cnt} !== 9'd0)
            $display("FAIL reset_wrap got %b/%0d want 0/0", mon.wrap, mon.wrap_cnt); else pass_cnt++;
        mon.err_clr = 1'b0;
    endtask

    task automatic test_up_count();
        logic err_seen = 1'b0;
        do_reset();
        for (int i = 0; i <= 14; i += 2) begin
            apply(4'(i), 1'b1);
            err_seen |= mon.err;
        end
        total_cnt++; if (mon.wrap !== 1'b0) $display("FAIL up_nowrap_early got %b want 0", mon.wrap); else pass_cnt++;
        apply(4'd0, 1'b1);
        err_seen |= mon.err;
        total_cnt++; if (mon.wrap !== EXP_WRAP) $display("FAIL up_wrap got %b want %b", mon.wrap, EXP_WRAP); else pass_cnt++;
        total_cnt++; if (mon.wrap_cnt !== EXP_WRAP_N) $display("FAIL up_wrap_cnt got %0d want %0d", mon.wrap_cnt, EXP_WRAP_N); else pass_cnt++;
        total_cnt++; if (mon.state !== 2'b01) $display("FAIL up_state got %0d want 1", mon.state); else pass_cnt++;
        apply(4'd2, 1'b1);
        err_seen |= mon.err;
        total_cnt++; if (mon.wrap !== 1'b0) $display("FAIL up_wrap_pulse got %b want 0", mon.wrap); else pass_cnt++;
        total_cnt++; if ({err_seen, mon.err_cnt} !== 9'd0)
            $display("FAIL up_no_err got %b/%0d want 0/0", err_seen, mon.err_cnt); else pass_cnt++;
    endtask

    task automatic test_direction();
        do_reset();
        apply(4'd4, 1'b1);
        apply(4'd6, 1'b0);
        apply(4'd4, 1'b0);
        apply(4'd2, 1'b0);
        total_cnt++; if (mon.err_cnt !== 8'd0) $display("FAIL dir_err_cnt got %0d want 0", mon.err_cnt); else pass_cnt++;
        total_cnt++; if (mon.state !== 2'b01) $display("FAIL dir_state got %0d want 1", mon.state); else pass_cnt++;
        total_cnt++; if (mon.count !== 4'd2) $display("FAIL dir_count got %0d want 2", mon.count); else pass_cnt++;
    endtask

    task automatic test_glitch();
        do_reset();
        apply(4'd2, 1'b1);
        apply(4'd4, 1'b1);
        apply(4'd10, 1'b1);
        total_cnt++; if (mon.err !== 1'b1) $display("FAIL glitch_err got %b want 1", mon.err); else pass_cnt++;
        apply(4'd12, 1'b1);
        total_cnt++; if (mon.err !== 1'b0) $display("FAIL glitch_err_pulse got %b want 0", mon.err); else pass_cnt++;
        total_cnt++; if (mon.err_cnt !== 8'd1) $display("FAIL glitch_err_cnt got %0d want 1", mon.err_cnt); else pass_cnt++;
        total_cnt++; if (mon.err_sticky !== 1'b1) $display("FAIL glitch_sticky got %b want 1", mon.err_sticky); else pass_cnt++;
        total_cnt++; if (mon.state !== 2'b01) $display("FAIL glitch_state got %0d want 1", mon.state); else pass_cnt++;
        total_cnt++; if (mon.count !== 4'd12) $display("FAIL glitch_count got %0d want 12", mon.count); else pass_cnt++;
    endtask

    task automatic test_fault();
        do_reset();
        apply(4'd2, 1'b1);
        apply(4'd8, 1'b1);
        apply(4'd3, 1'b1);
        total_cnt++; if (mon.state !== 2'b01) $display("FAIL fault_pre_state got %0d want 1", mon.state); else pass_cnt++;
        apply(4'd9, 1'b1);
        total_cnt++; if (mon.err_cnt !== 8'd3) $display("FAIL fault_err_cnt got %0d want 3", mon.err_cnt); else pass_cnt++;
        total_cnt++; if (mon.state !== 2'b10) $display("FAIL fault_state got %0d want 2", mon.state); else pass_cnt++;
        apply(4'd7, 1'b1);
        total_cnt++; if (mon.err_cnt !== 8'd3) $display("FAIL fault_hold_cnt got %0d want 3", mon.err_cnt); else pass_cnt++;
        total_cnt++; if (mon.err !== 1'b0) $display("FAIL fault_no_err got %b want 0", mon.err); else pass_cnt++;
        mon.err_clr = 1'b1;
        apply(4'd4, 1'b1);
        mon.err_clr = 1'b0;
        total_cnt++; if (mon.state !== 2'b00) $display("FAIL fault_clr_state got %0d want 0", mon.state); else pass_cnt++;
        total_cnt++; if ({mon.err_sticky, mon.err_cnt} !== 9'd0)
            $display("FAIL fault_clr_stats got %b/%0d want 0/0", mon.err_sticky, mon.err_cnt); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (260) apply(4'd1, 1'b1);
        total_cnt++; if (mon.err_cnt !== 8'd255) $display("FAIL sat_err_cnt got %0d want 255", mon.err_cnt); else pass_cnt++;
        total_cnt++; if (mon.state !== 2'b00) $display("FAIL sat_state got %0d want 0", mon.state); else pass_cnt++;
        mon.err_clr = 1'b1;
        apply(4'd3, 1'b1);
        mon.err_clr = 1'b0;
        total_cnt++; if (mon.err_cnt !== 8'd1) $display("FAIL sat_clr_cnt got %0d want 1", mon.err_cnt); else pass_cnt++;
        total_cnt++; if (mon.err_sticky !== 1'b1) $display("FAIL sat_clr_sticky got %b want 1", mon.err_sticky); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) apply(4'd1, 1'b1);
        apply(4'd6, 1'b1);
        apply(4'd8, 1'b1);
        total_cnt++; if (mon.err_cnt !== 8'd5) $display("FAIL mid_pre_cnt got %0d want 5", mon.err_cnt); else pass_cnt++;
        total_cnt++; if (mon.state !== 2'b01) $display("FAIL mid_pre_state got %0d want 1", mon.state); else pass_cnt++;
        reset = 1'b1;
        apply(4'd10, 1'b1);
        reset = 1'b0;
        total_cnt++; if ({mon.state, mon.count, mon.err, mon.err_sticky, mon.err_cnt} !== 16'd0)
            $display("FAIL mid_reset got st=%0d cnt=%0d err=%b sticky=%b ecnt=%0d want all 0",
                     mon.state, mon.count, mon.err, mon.err_sticky, mon.err_cnt); else pass_cnt++;
        // history gone: 12 would have matched the old track, now it only syncs
        apply(4'd12, 1'b1);
        apply(4'd2, 1'b1);
        total_cnt++; if (mon.err_cnt !== 8'd1) $display("FAIL mid_history got %0d want 1", mon.err_cnt); else pass_cnt++;
        apply(4'd4, 1'b1);
        mon.en = 1'b0;
        apply(4'd6, 1'b1);
        mon.en = 1'b1;
        total_cnt++; if (mon.state !== 2'b00) $display("FAIL en_off_state got %0d want 0", mon.state); else pass_cnt++;
        total_cnt++; if ({mon.err_sticky, mon.err_cnt} !== {1'b1, 8'd1})
            $display("FAIL en_off_stats got %b/%0d want 1/1", mon.err_sticky, mon.err_cnt); else pass_cnt++;
    endtask

    task automatic test_wrap_down();
        do_reset();
        apply(4'd2, 1'b0);
        apply(4'd0, 1'b0);
        total_cnt++; if (mon.wrap !== 1'b0) $display("FAIL down_nowrap got %b want 0", mon.wrap); else pass_cnt++;
        apply(4'd14, 1'b0);
        total_cnt++; if (mon.wrap !== EXP_WRAP) $display("FAIL down_wrap got %b want %b", mon.wrap, EXP_WRAP); else pass_cnt++;
        apply(4'd12, 1'b0);
        total_cnt++; if ({mon.wrap_cnt, mon.err_cnt} !== {EXP_WRAP_N, 8'd0})
            $display("FAIL down_counts got %0d/%0d want %0d/0", mon.wrap_cnt, mon.err_cnt, EXP_WRAP_N); else pass_cnt++;
    endtask

    initial begin
        mon.en = 1'b0;
        mon.err_clr = 1'b0;
        mon.Y = 1'b0;
        {mon.A, mon.B, mon.C, mon.D} = 4'd0;
        test_reset();
        test_up_count();
        test_direction();
        test_glitch();
        test_fault();
        test_saturation();
        test_reset_mid();
        test_wrap_down();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
